timestamp_generator: RTL and testbench

Free-running, run-gated timestamp counter supplying a monotonically increasing cycle count to the acquisition and packetising logic. It increments by one on every clock while `run` is high and holds otherwise. It wraps silently modulo 2^WIDTH and flags each wrap with a one-cycle pulse. A synchronous preset port lets software or test logic start counting from an arbitrary value.

---
 rtl/timestamp_generator.sv | 47 ++++
 tb/tb_timestamp_generator.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/timestamp_generator.sv
// Run-gated cycle counter with preset, one-cycle wrap pulse and a registered run flag.
// The timestamp output is the counter register itself, so every output is registered.
module timestamp_generator #(
   parameter int               WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             run,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] timestamp,
   output logic             wrap,
   output logic             running
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] timestamp_next;
   logic             wrap_next;

   // Load beats run; wrap only fires when an increment rolls all-ones over to zero.
   always_comb begin
      timestamp_next = timestamp;
      wrap_next      = 1'b0;
      if (load) begin
         timestamp_next = load_value;
      end else if (run) begin
         timestamp_next = timestamp + ONE;
         wrap_next      = &timestamp;
      end
   end

   // resetn is active-high despite its name.
   always_ff @(posedge clk) begin
      if (resetn) begin
         timestamp <= RESET_VALUE;
         wrap      <= 1'b0;
         running   <= 1'b0;
      end else begin
         timestamp <= timestamp_next;
         wrap      <= wrap_next;
         running   <= run;
      end
   end

endmodule

// File: tb/tb_timestamp_generator.sv
// Scoreboard bench for timestamp_generator: a 64-bit instance and an 8-bit instance
// preset to 250, each checked against its own reference model every clock.
module tb_timestamp_generator;

   typedef struct packed {
      logic [63:0] ts;
      logic        wrap;
      logic        running;
   } exp_t;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   // 64-bit instance
   logic        rst_a = 1'b1, run_a = 1'b0, load_a = 1'b0;
   logic [63:0] lv_a = '0;
   logic [63:0] ts_a;
   logic        wrap_a, running_a;

   // 8-bit instance
   logic        rst_b = 1'b1, run_b = 1'b0, load_b = 1'b0;
   logic [7:0]  lv_b = '0;
   logic [7:0]  ts_b;
   logic        wrap_b, running_b;

   timestamp_generator #(.WIDTH(64), .RESET_VALUE(64'd0)) dut_a (
      .clk(clk), .resetn(rst_a), .run(run_a), .load(load_a), .load_value(lv_a),
      .timestamp(ts_a), .wrap(wrap_a), .running(running_a)
   );

   timestamp_generator #(.WIDTH(8), .RESET_VALUE(8'd250)) dut_b (
      .clk(clk), .resetn(rst_b), .run(run_b), .load(load_b), .load_value(lv_b),
      .timestamp(ts_b), .wrap(wrap_b), .running(running_b)
   );

   int   errors = 0;
   int   checks = 0;
   exp_t q_a[$];
   exp_t q_b[$];
   logic [63:0] m_ts_a = '0;
   logic [7:0]  m_ts_b = '0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
      end
   endtask

   // Drive one clock of stimulus on instance A, predict, then compare on the far side of the edge.
   task automatic step_a(input logic rst, input logic run, input logic ld, input logic [63:0] lv);
      exp_t e, o;
      rst_a = rst; run_a = run; load_a = ld; lv_a = lv;
      e = '0;
      if (rst) begin
         m_ts_a = 64'd0;
      end else if (ld) begin
         m_ts_a = lv;
      end else if (run) begin
         e.wrap = (m_ts_a == 64'hFFFF_FFFF_FFFF_FFFF);
         m_ts_a = m_ts_a + 64'd1;
      end
      e.ts      = m_ts_a;
      e.running = rst ? 1'b0 : run;
      q_a.push_back(e);
      @(posedge clk);
      #1;
      if (q_a.size() == 0) begin
         chk("a_queue_empty", 64'd0, 64'd1);
      end else begin
         o = q_a.pop_front();
         $display("a: rst=%0b run=%0b load=%0b lv=0x%0h -> ts=0x%0h wrap=%0b running=%0b",
                  rst, run, ld, lv, ts_a, wrap_a, running_a);
         chk("a_ts", ts_a, o.ts);
         chk("a_wrap", {63'd0, wrap_a}, {63'd0, o.wrap});
         chk("a_running", {63'd0, running_a}, {63'd0, o.running});
      end
   endtask

   task automatic step_b(input logic rst, input logic run, input logic ld, input logic [7:0] lv);
      exp_t e, o;
      rst_b = rst; run_b = run; load_b = ld; lv_b = lv;
      e = '0;
      if (rst) begin
         m_ts_b = 8'd250;
      end else if (ld) begin
         m_ts_b = lv;
      end else if (run) begin
         e.wrap = (m_ts_b == 8'hFF);
         m_ts_b = m_ts_b + 8'd1;
      end
      e.ts      = {56'd0, m_ts_b};
      e.running = rst ? 1'b0 : run;
      q_b.push_back(e);
      @(posedge clk);
      #1;
      if (q_b.size() == 0) begin
         chk("b_queue_empty", 64'd0, 64'd1);
      end else begin
         o = q_b.pop_front();
         $display("b: rst=%0b run=%0b load=%0b lv=%0d -> ts=%0d wrap=%0b running=%0b",
                  rst, run, ld, lv, ts_b, wrap_b, running_b);
         chk("b_ts", {56'd0, ts_b}, o.ts);
         chk("b_wrap", {63'd0, wrap_b}, {63'd0, o.wrap});
         chk("b_running", {63'd0, running_b}, {63'd0, o.running});
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int wraps;

      // Reset held 3 clocks, then idle: counter stays at 0.
      repeat (3) step_a(1'b1, 1'b1, 1'b0, 64'd0);
      chk("rst_ts", ts_a, 64'd0);
      chk("rst_running", {63'd0, running_a}, 64'd0);
      repeat (3) step_a(1'b0, 1'b0, 1'b0, 64'd0);
      chk("idle_ts", ts_a, 64'd0);

      // Basic count, hold, resume.
      repeat (100) step_a(1'b0, 1'b1, 1'b0, 64'd0);
      chk("count_100", ts_a, 64'd100);
      repeat (10) step_a(1'b0, 1'b0, 1'b0, 64'd0);
      chk("hold_100", ts_a, 64'd100);
      repeat (5) step_a(1'b0, 1'b1, 1'b0, 64'd0);
      chk("resume_105", ts_a, 64'd105);

      // Load beats run in the same cycle.
      step_a(1'b0, 1'b1, 1'b1, 64'd1000);
      chk("load_over_run", ts_a, 64'd1000);
      step_a(1'b0, 1'b1, 1'b0, 64'd0);
      chk("after_load", ts_a, 64'd1001);

      // Loading zero must not pulse wrap.
      step_a(1'b0, 1'b0, 1'b1, 64'd0);
      chk("load0_nowrap", {63'd0, wrap_a}, 64'd0);

      // Overflow from -50.
      step_a(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFCE);
      wraps = 0;
      repeat (50) begin
         step_a(1'b0, 1'b1, 1'b0, 64'd0);
         if (wrap_a) wraps++;
      end
      chk("ovf_ts0", ts_a, 64'd0);
      chk("ovf_wrap_pulse", {63'd0, wrap_a}, 64'd1);
      repeat (50) begin
         step_a(1'b0, 1'b1, 1'b0, 64'd0);
         if (wrap_a) wraps++;
      end
      chk("ovf_ts50", ts_a, 64'd50);
      chk("ovf_wrap_count", wraps, 64'd1);

      // Reset mid-count with run held high.
      step_a(1'b0, 1'b0, 1'b1, 64'd12345);
      step_a(1'b0, 1'b1, 1'b0, 64'd0);
      chk("pre_midrst", ts_a, 64'd12346);
      step_a(1'b1, 1'b1, 1'b0, 64'd0);
      chk("midrst_ts", ts_a, 64'd0);
      for (int i = 1; i <= 3; i++) begin
         step_a(1'b0, 1'b1, 1'b0, 64'd0);
         chk("midrst_count", ts_a, 64'(i));
      end

      // 8-bit instance: reset value 250, wraps after 6 runs.
      repeat (2) step_b(1'b1, 1'b0, 1'b0, 8'd0);
      chk("w8_rst", {56'd0, ts_b}, 64'd250);
      repeat (6) step_b(1'b0, 1'b1, 1'b0, 8'd0);
      chk("w8_wrap_ts", {56'd0, ts_b}, 64'd0);
      chk("w8_wrap_pulse", {63'd0, wrap_b}, 64'd1);
      repeat (3) step_b(1'b0, 1'b1, 1'b0, 8'd0);
      chk("w8_ts3", {56'd0, ts_b}, 64'd3);
      chk("w8_wrap_low", {63'd0, wrap_b}, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
